// File: rtl/l1_mem_arbiter.sv
// Two-way arbiter sharing one CPU-wrapper memory port between the I-cache and D-cache.
// Simultaneous requests go to the D-cache unless L1ARB_ROUND_ROBIN_EN is defined (round robin).
module l1_mem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TYPE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_req,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_in,
  input  logic [TYPE_W-1:0] i_type,
  output logic [DATA_W-1:0] i_out,
  output logic              i_wait,
  // D-cache side
  input  logic              d_req,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic [TYPE_W-1:0] d_type,
  output logic [DATA_W-1:0] d_out,
  output logic              d_wait,
  // Shared memory port
  output logic              mem_req,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic [TYPE_W-1:0] mem_type,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              mem_wait,
  // Current owner
  output logic              grant_i,
  output logic              grant_d
);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e state_q, state_d;
  state_e both_pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef L1ARB_ROUND_ROBIN_EN
  // High when the D-cache was the most recently completed requester.
  logic last_d_q, last_d_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    last_d_d = last_d_q;
    if (!mem_wait) begin
      if (state_q == StGntI) begin
        last_d_d = 1'b0;
      end else if (state_q == StGntD) begin
        last_d_d = 1'b1;
      end
    end
  end

  assign both_pick = last_d_q ? StGntI : StGntD;
`else
  assign both_pick = StGntD;
`endif

  // Next state: the served requester's req is ignored at completion so the other side
  // gets the port without an idle gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
          state_d = both_pick;
        end else if (i_req) begin
          state_d = StGntI;
        end else if (d_req) begin
          state_d = StGntD;
        end
      end
      StGntI: begin
        if (!mem_wait) begin
          state_d = d_req ? StGntD : StIdle;
        end
      end
      StGntD: begin
        if (!mem_wait) begin
          state_d = i_req ? StGntI : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_in    = '0;
    mem_type  = '0;
    unique case (state_q)
      StGntI: begin
        grant_i   = 1'b1;
        mem_req   = 1'b1;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_in    = i_in;
        mem_type  = i_type;
      end
      StGntD: begin
        grant_d   = 1'b1;
        mem_req   = 1'b1;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_in    = d_in;
        mem_type  = d_type;
      end
      default: ;
    endcase
  end

  // A requester without the grant simply stalls on its own request.
  always_comb begin
    i_wait = grant_i ? mem_wait : i_req;
    i_out  = grant_i ? mem_out : '0;
    d_wait = grant_d ? mem_wait : d_req;
    d_out  = grant_d ? mem_out : '0;
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter: requester queues, a latency-programmable memory model
// and an in-order scoreboard of expected memory transactions.
module tb_l1_mem_arbiter;
  localparam int DW = 32;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst;
  logic i_req, i_write, d_req, d_write;
  logic [DW-1:0] i_addr, i_in, i_out, d_addr, d_in, d_out;
  logic [TW-1:0] i_type, d_type;
  logic i_wait, d_wait;
  logic mem_req, mem_write, mem_wait, grant_i, grant_d;
  logic [DW-1:0] mem_addr, mem_in, mem_out;
  logic [TW-1:0] mem_type;

  always #5 clk = ~clk;

  l1_mem_arbiter #(.DATA_W(DW), .TYPE_W(TW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_in(i_in), .i_type(i_type),
    .i_out(i_out), .i_wait(i_wait),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_in(d_in), .d_type(d_type),
    .d_out(d_out), .d_wait(d_wait),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_type(mem_type), .mem_out(mem_out), .mem_wait(mem_wait),
    .grant_i(grant_i), .grant_d(grant_d)
  );

  typedef struct packed {
    logic          wr;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] typ;
  } req_t;

  typedef struct packed {
    logic is_d;
    req_t r;
  } exp_t;

  req_t i_q[$];
  req_t d_q[$];
  exp_t exp_q[$];
  req_t cur_i, cur_d;
  int   errors = 0;
  int   checks = 0;
  int   lat = 2;
  int   cnt;
  int   gcyc = 0;
  bit   hand_i = 1'b0;
  bit   hand_d = 1'b0;

  function automatic logic [DW-1:0] model_out(input logic [DW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: completes on the lat-th cycle of each granted transaction.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (mem_req) cnt <= mem_wait ? cnt + 1 : 0;
    else cnt <= 0;
  end
  assign mem_wait = mem_req && (cnt < lat - 1);
  assign mem_out  = mem_req ? model_out(mem_addr) : 32'h0;

  function automatic req_t mk_req(input logic wr, input logic [DW-1:0] a, input logic [DW-1:0] d,
                                  input logic [TW-1:0] t);
    req_t r;
    r.wr = wr; r.addr = a; r.data = d; r.typ = t;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic is_d, input req_t r);
    exp_t e;
    e.is_d = is_d; e.r = r;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic complete(input logic is_d);
    exp_t e;
    chk("txn_len", 32'(gcyc), 32'(lat));
    gcyc = 0;
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_owner", 32'(is_d), 32'(e.is_d));
      chk("sb_addr", mem_addr, e.r.addr);
      chk("sb_data", mem_in, e.r.data);
      chk("sb_write", 32'(mem_write), 32'(e.r.wr));
      chk("sb_type", 32'(mem_type), 32'(e.r.typ));
    end
  endtask

  // One cycle: check at negedge, then update requesters just after the rising edge.
  task automatic step();
    bit done_i = 1'b0;
    bit done_d = 1'b0;
    @(negedge clk);
    if (hand_i) chk("handoff_to_i", 32'(grant_i), 32'd1);
    if (hand_d) chk("handoff_to_d", 32'(grant_d), 32'd1);
    hand_i = 1'b0;
    hand_d = 1'b0;
    chk("grant_exclusive", 32'(grant_i & grant_d), 32'd0);
    if (grant_i) begin
      gcyc++;
      chk("mem_req_i", 32'(mem_req), 32'd1);
      chk("mem_addr_i", mem_addr, cur_i.addr);
      chk("mem_in_i", mem_in, cur_i.data);
      chk("mem_write_i", 32'(mem_write), 32'(cur_i.wr));
      chk("mem_type_i", 32'(mem_type), 32'(cur_i.typ));
      chk("i_wait_gnt", 32'(i_wait), 32'(mem_wait));
      chk("i_out_gnt", i_out, model_out(cur_i.addr));
      chk("d_wait_held", 32'(d_wait), 32'(d_req));
      chk("d_out_held", d_out, 32'h0);
      if (!mem_wait) begin
        complete(1'b0);
        done_i = 1'b1;
        hand_d = d_req;
      end
    end else if (grant_d) begin
      gcyc++;
      chk("mem_req_d", 32'(mem_req), 32'd1);
      chk("mem_addr_d", mem_addr, cur_d.addr);
      chk("mem_in_d", mem_in, cur_d.data);
      chk("mem_write_d", 32'(mem_write), 32'(cur_d.wr));
      chk("mem_type_d", 32'(mem_type), 32'(cur_d.typ));
      chk("d_wait_gnt", 32'(d_wait), 32'(mem_wait));
      chk("d_out_gnt", d_out, model_out(cur_d.addr));
      chk("i_wait_held", 32'(i_wait), 32'(i_req));
      chk("i_out_held", i_out, 32'h0);
      if (!mem_wait) begin
        complete(1'b1);
        done_d = 1'b1;
        hand_i = i_req;
      end
    end else begin
      gcyc = 0;
      chk("idle_mem_req", 32'(mem_req), 32'd0);
      chk("idle_mem_addr", mem_addr, 32'h0);
      chk("idle_mem_in", mem_in, 32'h0);
      chk("idle_i_wait", 32'(i_wait), 32'(i_req));
      chk("idle_d_wait", 32'(d_wait), 32'(d_req));
      chk("idle_outs", i_out | d_out, 32'h0);
    end
    @(posedge clk);
    #1;
    if (done_i) i_req = 1'b0;
    if (done_d) d_req = 1'b0;
    if (!i_req && i_q.size() != 0) begin
      cur_i = i_q.pop_front();
      i_req = 1'b1; i_write = cur_i.wr; i_addr = cur_i.addr; i_in = cur_i.data;
      i_type = cur_i.typ;
    end
    if (!d_req && d_q.size() != 0) begin
      cur_d = d_q.pop_front();
      d_req = 1'b1; d_write = cur_d.wr; d_addr = cur_d.addr; d_in = cur_d.data;
      d_type = cur_d.typ;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || i_req || d_req || grant_i || grant_d) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    req_t ri, rd;
    rst = 1'b1;
    i_req = 1'b0; i_write = 1'b0; i_addr = '0; i_in = '0; i_type = '0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_in = '0; d_type = '0;

    // Reset state
    @(negedge clk);
    chk("rst_grant_i", 32'(grant_i), 32'd0);
    chk("rst_grant_d", 32'(grant_d), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Lone I request, memory completes on the 3rd granted cycle
    lat = 3;
    ri = mk_req(1'b0, 32'h0000_0040, 32'h1111_2222, 3'b001);
    i_q.push_back(ri);
    exp_q.push_back(mk_exp(1'b0, ri));
    step();
    step();
    chk("arb_latency_i", 32'(grant_i), 32'd1);
    chk("mem_addr_cycle1", mem_addr, 32'h0000_0040);
    run_until_idle(20);
    chk("idle_after_i", 32'(grant_i | grant_d), 32'd0);

    // Asynchronous reset in the middle of a stalled D transaction
    lat = 50;
    rd = mk_req(1'b0, 32'h0000_0300, 32'h0, 3'b000);
    d_q.push_back(rd);
    exp_q.push_back(mk_exp(1'b1, rd));
    step();
    step();
    chk("rst_test_grant_d", 32'(grant_d), 32'd1);
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_grant_d", 32'(grant_d), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'h0);
    chk("rst_mid_d_wait", 32'(d_wait), 32'd1);
    d_req = 1'b0;
    exp_q.delete();
    gcyc = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_after_rst", 32'(grant_i | grant_d), 32'd0);

    // Simultaneous requests right after reset
    lat = 2;
    ri = mk_req(1'b0, 32'h0000_0500, 32'h0, 3'b011);
    rd = mk_req(1'b0, 32'h0000_0600, 32'h0, 3'b100);
    i_q.push_back(ri);
    d_q.push_back(rd);
`ifdef L1ARB_ROUND_ROBIN_EN
    exp_q.push_back(mk_exp(1'b0, ri));
    exp_q.push_back(mk_exp(1'b1, rd));
`else
    exp_q.push_back(mk_exp(1'b1, rd));
    exp_q.push_back(mk_exp(1'b0, ri));
`endif
    step();
    run_until_idle(30);

    // D write: all request fields muxed through
    lat = 2;
    rd = mk_req(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 3'b010);
    d_q.push_back(rd);
    exp_q.push_back(mk_exp(1'b1, rd));
    step();
    step();
    chk("wr_grant_d", 32'(grant_d), 32'd1);
    chk("wr_mem_write", 32'(mem_write), 32'd1);
    chk("wr_mem_in", mem_in, 32'hDEAD_BEEF);
    chk("wr_mem_type", 32'(mem_type), 32'd2);
    run_until_idle(20);

    // D waits behind a 5-cycle I transaction, then takes over without a gap
    lat = 5;
    ri = mk_req(1'b1, 32'h0000_0100, 32'hCAFE_0001, 3'b101);
    rd = mk_req(1'b0, 32'h0000_0200, 32'h0, 3'b110);
    i_q.push_back(ri);
    exp_q.push_back(mk_exp(1'b0, ri));
    step();
    d_q.push_back(rd);
    exp_q.push_back(mk_exp(1'b1, rd));
    run_until_idle(40);

    // Both sides re-request immediately for six transactions
    lat = 2;
    for (int k = 0; k < 3; k++) begin
      i_q.push_back(mk_req(1'b0, 32'h0000_1000 + 32'(k * 4), 32'h0, 3'b001));
      d_q.push_back(mk_req(1'b1, 32'h0000_2000 + 32'(k * 4), 32'hABC0_0000 + 32'(k), 3'b010));
    end
    for (int k = 0; k < 3; k++) begin
`ifdef L1ARB_ROUND_ROBIN_EN
      exp_q.push_back(mk_exp(1'b0, i_q[k]));
      exp_q.push_back(mk_exp(1'b1, d_q[k]));
`else
      exp_q.push_back(mk_exp(1'b1, d_q[k]));
      exp_q.push_back(mk_exp(1'b0, i_q[k]));
`endif
    end
    step();
    run_until_idle(60);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
L1_MEM_ARBITER -- requirements
Module: l1_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning address and data width.
REQ-002 SHALL have parameter TYPE_W, default 3, meaning access-type field width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports i_req, i_write (input, 1), i_addr, i_in (input, DATA_W) and i_type (input, TYPE_W), meaning the I-cache miss request.
REQ-006 SHALL have ports i_out (output, DATA_W) and i_wait (output, 1), meaning the I-cache response.
REQ-007 SHALL have ports d_req, d_write (input, 1), d_addr, d_in (input, DATA_W) and d_type (input, TYPE_W), meaning the D-cache miss or write-through request.
REQ-008 SHALL have ports d_out (output, DATA_W) and d_wait (output, 1), meaning the D-cache response.
REQ-009 SHALL have ports mem_req, mem_write (output, 1), mem_addr, mem_in (output, DATA_W) and mem_type (output, TYPE_W), meaning the shared CPU-wrapper memory request.
REQ-010 SHALL have ports mem_out (input, DATA_W) and mem_wait (input, 1), meaning the shared memory response.
REQ-011 SHALL have ports grant_i and grant_d (output, 1), meaning the current owner of the memory port.

Function
REQ-012 SHALL implement a registered FSM with states IDLE, GNT_I and GNT_D.
REQ-013 SHALL, in IDLE, move to GNT_I if only i_req=1, to GNT_D if only d_req=1, resolve i_req=d_req=1 per REQ-024/025, and stay in IDLE otherwise.
REQ-014 SHALL drive grant_i=1 only in GNT_I and grant_d=1 only in GNT_D; arbitration latency is 1 cycle (request sampled at edge N, mem_req=1 during cycle N+1).
REQ-015 SHALL, in GNT_x, drive mem_req=1 and mux mem_write/mem_addr/mem_in/mem_type from requester x; in IDLE it drives all mem_* outputs 0.
REQ-016 SHALL define transaction completion as a rising edge in GNT_x with mem_wait=0.
REQ-017 SHALL, at completion, ignore the served requester's req (still high that cycle) and go to the other GNT state if the other req=1, else to IDLE.
REQ-018 SHALL never change the grant before completion; requester inputs are required to stay stable while req=1.
REQ-019 SHALL drive x_wait = mem_wait and x_out = mem_out for the granted requester x.
REQ-020 SHALL drive x_wait = x_req and x_out = 0 for a requester that is not granted.
REQ-021 SHALL keep GNT_x if x_req drops before completion (protocol violation); the memory transaction is allowed to finish.

Reset
REQ-022 SHALL, while rst=1 (asynchronous, including mid-transaction), force state IDLE, grant_i=grant_d=0, mem_req=0 and all mem_* outputs 0, and set the last-served pointer to D.
REQ-023 SHALL, on the first edge after rst deasserts, arbitrate normally per REQ-013.

Configuration
REQ-024 SHALL, with macro L1ARB_ROUND_ROBIN_EN defined, resolve a simultaneous request in IDLE to the requester not recorded as last-served; the last-served pointer updates at every completion.
REQ-025 SHALL, without L1ARB_ROUND_ROBIN_EN, resolve a simultaneous request in IDLE to the D-cache (fixed priority) with no pointer logic; REQ-017 handoff is unchanged.

Verification
REQ-026 SHALL be checked by: rst pulsed mid-GNT_D with mem_wait=1 -> mem_req=0 and grant_d=0 immediately, IDLE after release.
REQ-027 SHALL be checked by: only i_req, i_addr=0x0000_0040, mem_wait low at 3rd granted cycle -> mem_addr=0x40 from cycle 1; i_wait=0 and i_out=mem_out at completion; IDLE next.
REQ-028 SHALL be checked by: i_req and d_req asserted together after reset -> RR build: GNT_I first then GNT_D with no IDLE gap; fixed build: GNT_D first then GNT_I.
REQ-029 SHALL be checked by: d_req held during a 5-cycle I transaction -> d_wait=1 throughout, d_out=0, mem_* unchanged from I values until completion.
REQ-030 SHALL be checked by: RR build, both requesters re-requesting immediately for 6 transactions -> strict alternation I,D,I,D,I,D.
REQ-031 SHALL be checked by: d_write=1, d_in=0xDEAD_BEEF, d_type=3'b010 -> mem_write=1, mem_in=0xDEADBEEF, mem_type=3'b010 while grant_d=1.
